// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard-control, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if;
    logic        PCWrite;
    logic        IF_ID_write;
    logic        flush;
    logic [31:0] target_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_valid;
    modport master (
        input  PCWrite, IF_ID_write, flush, target_pc, imem_ready, imem_rdata,
        output imem_req, imem_addr, IF_ID_pc, IF_ID_inst, IF_ID_valid
    );
    modport slave (
        output PCWrite, IF_ID_write, flush, target_pc, imem_ready, imem_rdata,
        input  imem_req, imem_addr, IF_ID_pc, IF_ID_inst, IF_ID_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing, instruction-memory requests and the IF/ID register,
// with a skid buffer for stalls and a drain state for redirects during an outstanding request.
module fetch_stage (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {FETCH, HELD, DRAIN} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, skid_q, skid_d, redir_q, redir_d;
    logic [31:0] if_pc_q, if_pc_d, if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic        stall, rdy, load;
    logic [31:0] tgt;
    always_comb begin
        stall      = !bus.PCWrite || !bus.IF_ID_write;
        tgt        = bus.target_pc & ~32'd3;
        rdy        = bus.imem_ready && state_q != HELD;
        load       = !bus.flush && !stall && (state_q == HELD || (state_q == FETCH && rdy));
        state_d    = state_q;
        pc_d       = pc_q;
        skid_d     = skid_q;
        redir_d    = redir_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = (bus.flush || !stall) ? NOP : if_inst_q;
        if_valid_d = (bus.flush || !stall) ? 1'b0 : if_valid_q;
        if (bus.flush) begin
            // a completing or already-buffered response is discarded; otherwise wait it out in DRAIN
            pc_d    = (state_q == HELD || rdy) ? tgt : pc_q;
            redir_d = (state_q == HELD || rdy) ? redir_q : tgt;
            state_d = (state_q == HELD || rdy) ? FETCH : DRAIN;
        end else if (state_q == DRAIN) begin
            pc_d    = rdy ? redir_q : pc_q;
            state_d = rdy ? FETCH : DRAIN;
        end else if (load) begin
            if_pc_d    = pc_q;
            if_inst_d  = (state_q == HELD) ? skid_q : bus.imem_rdata;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = FETCH;
        end else if (stall && rdy) begin
            skid_d  = bus.imem_rdata;
            state_d = HELD;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= '0;
            skid_q     <= '0;
            redir_q    <= '0;
            if_pc_q    <= '0;
            if_inst_q  <= NOP;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            skid_q     <= skid_d;
            redir_q    <= redir_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end
    // the outstanding request in DRAIN is still on pc_q, since pc only moves once it completes
    assign bus.imem_req    = !reset && state_q != HELD;
    assign bus.imem_addr   = pc_q;
    assign bus.IF_ID_pc    = if_pc_q;
    assign bus.IF_ID_inst  = if_inst_q;
    assign bus.IF_ID_valid = if_valid_q;
endmodule
